// File: rtl/pulse_event_capture_pkg.sv
// cito_evt_pkg: shared types and width helpers for the pulse event capture path.
// Holds the FSM state enum, the default-width event record and width derivations.
package cito_evt_pkg;

  localparam int DEF_DWIDTH     = 14;
  localparam int DEF_WIDTH_BITS = 16;
  localparam int DEF_TSWIDTH    = 32;

  function automatic int area_w(input int dw, input int wb);
    return dw + wb;
  endfunction

  function automatic int cusum_w(input int dw);
    return 2 * dw;
  endfunction

  localparam int DEF_AREA_W  = DEF_DWIDTH + DEF_WIDTH_BITS;
  localparam int DEF_CUSUM_W = 2 * DEF_DWIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_REPORT,
    S_HOLDOFF
  } state_t;

  typedef struct packed {
    logic [DEF_DWIDTH-1:0]     peak;
    logic [DEF_WIDTH_BITS-1:0] width;
    logic [DEF_AREA_W-1:0]     area;
    logic [DEF_CUSUM_W-1:0]    cmax;
    logic [DEF_TSWIDTH-1:0]    tstamp;
  } evt_rec_t;

endpackage

// File: rtl/pulse_event_capture_if.sv
// Event record valid/ready bundle towards the readout FIFO.
// master: capture block drives record + EVT_VALID; slave: drives EVT_READY.
interface pulse_event_capture_if
  import cito_evt_pkg::*;
#(
  parameter int DWIDTH     = 14,
  parameter int WIDTH_BITS = 16,
  parameter int TSWIDTH    = 32
);

  logic                                 EVT_VALID;
  logic                                 EVT_READY;
  logic [DWIDTH-1:0]                    EVT_PEAK;
  logic [WIDTH_BITS-1:0]                EVT_WIDTH;
  logic [area_w(DWIDTH,WIDTH_BITS)-1:0] EVT_AREA;
  logic [cusum_w(DWIDTH)-1:0]           EVT_CUSUM_MAX;
  logic [TSWIDTH-1:0]                   EVT_TIME;

  modport master (
    output EVT_VALID,
    output EVT_PEAK,
    output EVT_WIDTH,
    output EVT_AREA,
    output EVT_CUSUM_MAX,
    output EVT_TIME,
    input  EVT_READY
  );

  modport slave (
    input  EVT_VALID,
    input  EVT_PEAK,
    input  EVT_WIDTH,
    input  EVT_AREA,
    input  EVT_CUSUM_MAX,
    input  EVT_TIME,
    output EVT_READY
  );

endinterface

// File: rtl/pulse_event_capture_stats.sv
// evt_stats_accum: width/area/peak/max-CUSUM registers for one pulse.
// Ports: CLOCK, RESET, load (start pulse), update (extend pulse), data, cusum -> stats.
module evt_stats_accum
  import cito_evt_pkg::*;
#(
  parameter int DWIDTH     = 14,
  parameter int WIDTH_BITS = 16
) (
  input  logic                                 CLOCK,
  input  logic                                 RESET,
  input  logic                                 load,
  input  logic                                 update,
  input  logic [DWIDTH-1:0]                    data,
  input  logic [cusum_w(DWIDTH)-1:0]           cusum,
  output logic [WIDTH_BITS-1:0]                width,
  output logic [area_w(DWIDTH,WIDTH_BITS)-1:0] area,
  output logic [DWIDTH-1:0]                    peak,
  output logic [cusum_w(DWIDTH)-1:0]           cmax
);

  localparam int AW = area_w(DWIDTH, WIDTH_BITS);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      width <= '0;
      area  <= '0;
      peak  <= '0;
      cmax  <= '0;
    end else if (load) begin
      width <= WIDTH_BITS'(1);
      area  <= AW'(data);
      peak  <= data;
      cmax  <= cusum;
    end else if (update) begin
      // width sticks at all-ones; the other stats keep tracking
      if (width != '1)
        width <= width + WIDTH_BITS'(1);
      area <= area + AW'(data);
      if (data > peak)
        peak <= data;
      if (cusum > cmax)
        cmax <= cusum;
    end
  end

endmodule

// File: rtl/pulse_event_capture.sv
// pulse_event_capture: builds one event record per qualified detector pulse.
// Ports: CLOCK, RESET, ENABLE, DATA_IN, TRIGGER, CUSUM, evt (record handshake),
// EVT_DROPPED, BUSY. Macro CITO_EVT_TIMESTAMP_EN enables the timestamp counter.
module pulse_event_capture
  import cito_evt_pkg::*;
#(
  parameter int DWIDTH     = 14,
  parameter int WIDTH_BITS = 16,
  parameter int MIN_WIDTH  = 4,
  parameter int HOLDOFF    = 32,
  parameter int TSWIDTH    = 32
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  ENABLE,
  input  logic [DWIDTH-1:0]     DATA_IN,
  input  logic                  TRIGGER,
  input  logic [2*DWIDTH-1:0]   CUSUM,
  pulse_event_capture_if.master evt,
  output logic [15:0]           EVT_DROPPED,
  output logic                  BUSY
);

  localparam int AW = area_w(DWIDTH, WIDTH_BITS);
  localparam int CW = cusum_w(DWIDTH);
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [HW-1:0] HLAST =
    HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam logic [WIDTH_BITS-1:0] MIN_W =
    WIDTH_BITS'(MIN_WIDTH);

  state_t                state;
  logic                  valid;
  logic [HW-1:0]         hcnt;
  logic                  trig_prev;
  logic                  load;
  logic                  update;
  logic                  trig_rise;
  logic [WIDTH_BITS-1:0] width;
  logic [AW-1:0]         area;
  logic [DWIDTH-1:0]     peak;
  logic [CW-1:0]         cmax;

  assign load      = (state == S_IDLE) && ENABLE && TRIGGER;
  assign update    = (state == S_PULSE) && ENABLE && TRIGGER;
  assign trig_rise = ENABLE && TRIGGER && !trig_prev;
  assign BUSY      = (state != S_IDLE);

  evt_stats_accum #(
    .DWIDTH     (DWIDTH),
    .WIDTH_BITS (WIDTH_BITS)
  ) u_stats (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .load   (load),
    .update (update),
    .data   (DATA_IN),
    .cusum  (CUSUM),
    .width  (width),
    .area   (area),
    .peak   (peak),
    .cmax   (cmax)
  );

  assign evt.EVT_VALID     = valid;
  assign evt.EVT_PEAK      = peak;
  assign evt.EVT_WIDTH     = width;
  assign evt.EVT_AREA      = area;
  assign evt.EVT_CUSUM_MAX = cmax;

`ifdef CITO_EVT_TIMESTAMP_EN
  logic [TSWIDTH-1:0] ts_cnt;
  logic [TSWIDTH-1:0] ts_evt;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      ts_cnt <= '0;
      ts_evt <= '0;
    end else begin
      if (ENABLE)
        ts_cnt <= ts_cnt + TSWIDTH'(1);
      if (load)
        ts_evt <= ts_cnt;
    end
  end

  assign evt.EVT_TIME = ts_evt;
`else
  assign evt.EVT_TIME = TSWIDTH'(0);
`endif

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state       <= S_IDLE;
      valid       <= 1'b0;
      hcnt        <= '0;
      trig_prev   <= 1'b0;
      EVT_DROPPED <= '0;
    end else begin
      if (ENABLE)
        trig_prev <= TRIGGER;
      if (trig_rise &&
          (state == S_REPORT || state == S_HOLDOFF) &&
          EVT_DROPPED != 16'hFFFF)
        EVT_DROPPED <= EVT_DROPPED + 16'd1;
      unique case (state)
        S_IDLE: begin
          if (load)
            state <= S_PULSE;
        end
        S_PULSE: begin
          if (ENABLE && !TRIGGER) begin
            hcnt <= '0;
            if (width >= MIN_W) begin
              state <= S_REPORT;
              valid <= 1'b1;
            end else begin
              state <= S_HOLDOFF;
            end
          end
        end
        S_REPORT: begin
          // handshake ignores ENABLE
          if (evt.EVT_READY) begin
            valid <= 1'b0;
            state <= S_HOLDOFF;
          end
        end
        S_HOLDOFF: begin
          if (HOLDOFF == 0)
            state <= S_IDLE;
          else if (ENABLE) begin
            if (hcnt == HLAST)
              state <= S_IDLE;
            else
              hcnt <= hcnt + HW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
